imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 134 +++++++++++++
 tb/tb_imem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: single-outstanding instruction fetch responder backed by a
// word-addressed memory that is filled through a separate load port.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req_valid/req_ready fetch request handshake, req_addr is a byte address
//   rsp_valid/rsp_ready response handshake carrying rsp_ins and rsp_err
//   wr_en/wr_addr/wr_data  load-port word write, usable in any state
//   busy                high whenever a request is outstanding
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_ins,
  output logic        rsp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        busy
);

  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LO_33  = {1'b0, BASE_ADDR};
  // 33-bit upper bound so a window ending at 2^32 does not wrap to zero
  localparam logic [32:0] HI_33  = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic        LAT_ONE = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] ins_q;
  logic        err_q;
  logic        busy_q;

  logic [31:0] mem_q [0:DEPTH_WORDS-1];

  // Aligned and inside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS)
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} >= LO_33) && ({1'b0, a} < HI_33);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  // Load port; memory is deliberately not reset, and writes during reset are dropped
  always_ff @(posedge clk) begin
    if (!reset && wr_en && addr_ok(wr_addr)) begin
      mem_q[word_idx(wr_addr)] <= wr_data;
    end
  end

  // Request FSM; the response word is captured at acceptance so later
  // writes (including one on the same edge) never alter it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      ins_q   <= 32'h0000_0000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            err_q   <= !addr_ok(req_addr);
            ins_q   <= addr_ok(req_addr) ? mem_q[word_idx(req_addr)] : 32'h0000_0000;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (LAT_ONE) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              cnt_q   <= 4'd0;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT_M1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_ins   = ins_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (LATENCY 2, 1, 15)
// share clock, reset, address and load port; each has its own req_valid.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rv1 = 1'b0, rv2 = 1'b0, rv15 = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        rsp_ready = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;

  logic        rdy1, vld1, err1, busy1;
  logic        rdy2, vld2, err2, busy2;
  logic        rdy15, vld15, err15, busy15;
  logic [31:0] ins1, ins2, ins15;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rdy2), .req_addr(req_addr),
    .rsp_valid(vld2), .rsp_ready(rsp_ready), .rsp_ins(ins2), .rsp_err(err2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy2));

  imem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .req_addr(req_addr),
    .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_ins(ins1), .rsp_err(err1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy1));

  imem_responder #(.LATENCY(15)) dut15 (
    .clk(clk), .reset(reset), .req_valid(rv15), .req_ready(rdy15), .req_addr(req_addr),
    .rsp_valid(vld15), .rsp_ready(rsp_ready), .rsp_ins(ins15), .rsp_err(err15),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy15));

  // Advance one edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_vld(input int w);
    if (w == 1) return vld1;
    if (w == 15) return vld15;
    return vld2;
  endfunction

  function automatic logic [31:0] sel_ins(input int w);
    if (w == 1) return ins1;
    if (w == 15) return ins15;
    return ins2;
  endfunction

  function automatic logic sel_err(input int w);
    if (w == 1) return err1;
    if (w == 15) return err15;
    return err2;
  endfunction

  task automatic set_rv(input int w, input logic v);
    if (w == 1) rv1 = v;
    else if (w == 15) rv15 = v;
    else rv2 = v;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // One request with rsp_ready high; lat is edges from acceptance to first
  // sampled rsp_valid (0 on timeout). Leaves the DUT idle.
  task automatic run_req(input int w, input logic [31:0] a, output int lat,
                         output logic [31:0] ins, output logic err);
    int n;
    rsp_ready = 1'b1;
    req_addr = a;
    set_rv(w, 1'b1);
    tick();
    set_rv(w, 1'b0);
    n = 1;
    while (!sel_vld(w) && n < 40) begin
      tick();
      n++;
    end
    if (sel_vld(w)) begin
      lat = n; ins = sel_ins(w); err = sel_err(w);
    end else begin
      lat = 0; ins = 32'hxxxx_xxxx; err = 1'bx;
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", rdy2); end
    n_tests++; if (vld2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", vld2); end
    n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy2); end
    n_tests++; if (ins2 !== 32'h0) begin n_fail++; $display("FAIL reset_ins got=%h exp=0", ins2); end
    n_tests++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err2); end
    reset = 1'b0;
    tick();
    n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", rdy2); end
  endtask

  task automatic test_basic();
    write_word(32'h0000_3000, 32'h2008_0005);
    rsp_ready = 1'b1;
    req_addr = 32'h0000_3000;
    rv2 = 1'b1;
    tick();
    rv2 = 1'b0;
    n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy2); end
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL basic_ready_wait got=%b exp=0", rdy2); end
    n_tests++; if (vld2 !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", vld2); end
    tick();
    n_tests++; if (vld2 !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", vld2); end
    n_tests++; if (ins2 !== 32'h2008_0005) begin n_fail++; $display("FAIL basic_ins got=%h exp=20080005", ins2); end
    n_tests++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", err2); end
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL basic_ready_resp got=%b exp=0", rdy2); end
    tick();
    n_tests++; if (vld2 !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got=%b exp=0", vld2); end
    n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got=%b exp=1", rdy2); end
    n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_clear got=%b exp=0", busy2); end
  endtask

  task automatic test_backpressure();
    int extra;
    rsp_ready = 1'b0;
    req_addr = 32'h0000_3000;
    rv2 = 1'b1;
    tick();
    rv2 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (vld2 !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, vld2); end
      n_tests++; if (ins2 !== 32'h2008_0005) begin n_fail++; $display("FAIL bp_ins[%0d] got=%h exp=20080005", i, ins2); end
      n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, rdy2); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_tests++; if (vld2 !== 1'b0) begin n_fail++; $display("FAIL bp_consumed got=%b exp=0", vld2); end
    n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%b exp=1", rdy2); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vld2) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL bp_single_rsp extra=%0d exp=0", extra); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5];
    logic        exp_err [5];
    logic [31:0] exp_ins [5];
    int          lat;
    logic [31:0] ins;
    logic        err;
    addrs = '{32'h0000_3002, 32'h0000_2FFC, 32'h0000_4000, 32'hFFFF_FFFC, 32'h0000_3FFC};
    exp_err = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_ins = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
    write_word(32'h0000_3FFC, 32'hCAFE_F00D);
    // out-of-range writes must be dropped and never alias onto a valid word
    write_word(32'h0000_4000, 32'hDEAD_0001);
    write_word(32'h0000_2FFC, 32'hDEAD_0002);
    for (int i = 0; i < 5; i++) begin
      run_req(2, addrs[i], lat, ins, err);
      n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL err_lat[%h] got=%0d exp=2", addrs[i], lat); end
      n_tests++; if (err !== exp_err[i]) begin n_fail++; $display("FAIL err_flag[%h] got=%b exp=%b", addrs[i], err, exp_err[i]); end
      n_tests++; if (ins !== exp_ins[i]) begin n_fail++; $display("FAIL err_ins[%h] got=%h exp=%h", addrs[i], ins, exp_ins[i]); end
    end
    run_req(2, 32'h0000_3000, lat, ins, err);
    n_tests++; if (ins !== 32'h2008_0005) begin n_fail++; $display("FAIL err_no_alias got=%h exp=20080005", ins); end
  endtask

  task automatic test_collision();
    int          lat;
    logic [31:0] ins;
    logic        err;
    write_word(32'h0000_3010, 32'hAAAA_AAAA);
    rsp_ready = 1'b1;
    req_addr = 32'h0000_3010;
    rv2 = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h0000_3010; wr_data = 32'h5555_5555;
    tick();
    rv2 = 1'b0;
    // write after acceptance must not reach the outstanding response either
    wr_data = 32'h5555_5555;
    tick();
    wr_en = 1'b0;
    n_tests++; if (vld2 !== 1'b1) begin n_fail++; $display("FAIL coll_valid got=%b exp=1", vld2); end
    n_tests++; if (ins2 !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL coll_old got=%h exp=aaaaaaaa", ins2); end
    tick();
    run_req(2, 32'h0000_3010, lat, ins, err);
    n_tests++; if (ins !== 32'h5555_5555) begin n_fail++; $display("FAIL coll_new got=%h exp=55555555", ins); end
  endtask

  task automatic test_reset_mid();
    int          seen;
    int          lat;
    logic [31:0] ins;
    logic        err;
    write_word(32'h0000_3020, 32'h1357_9BDF);
    rsp_ready = 1'b1;
    req_addr = 32'h0000_3020;
    rv2 = 1'b1;
    tick();
    rv2 = 1'b0;
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h0000_3020; wr_data = 32'hFFFF_0000;
    tick();
    wr_en = 1'b0;
    n_tests++; if (vld2 !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", vld2); end
    n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_reset got=%b exp=0", rdy2); end
    reset = 1'b0;
    tick();
    n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_release got=%b exp=1", rdy2); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (vld2) seen++;
      tick();
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rmid_no_rsp count=%0d exp=0", seen); end
    run_req(2, 32'h0000_3020, lat, ins, err);
    n_tests++; if (ins !== 32'h1357_9BDF) begin n_fail++; $display("FAIL rmid_mem_kept got=%h exp=13579bdf", ins); end
  endtask

  task automatic test_latency();
    int          lat;
    logic [31:0] ins;
    logic        err;
    write_word(32'h0000_3040, 32'h0BAD_CAFE);
    run_req(1, 32'h0000_3040, lat, ins, err);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL lat1 got=%0d exp=1", lat); end
    n_tests++; if (ins !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL lat1_ins got=%h exp=0badcafe", ins); end
    run_req(15, 32'h0000_3040, lat, ins, err);
    n_tests++; if (lat !== 15) begin n_fail++; $display("FAIL lat15 got=%0d exp=15", lat); end
    n_tests++; if (ins !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL lat15_ins got=%h exp=0badcafe", ins); end
    run_req(2, 32'h0000_3040, lat, ins, err);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL lat2 got=%0d exp=2", lat); end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int rsps;
    rsp_ready = 1'b1;
    req_addr = 32'h0000_3000;
    rv2 = 1'b1;
    accepts = 0;
    rsps = 0;
    for (int i = 0; i < 9; i++) begin
      if (rdy2) accepts++;
      if (vld2) rsps++;
      tick();
    end
    rv2 = 1'b0;
    n_tests++; if (accepts !== 3) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=3", accepts); end
    n_tests++; if (rsps !== 3) begin n_fail++; $display("FAIL b2b_rsps got=%0d exp=3", rsps); end
    tick();
    n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got=%b exp=1", rdy2); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_collision();
    test_reset_mid();
    test_latency();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
